// File: rtl/ccff_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_e;

  localparam int CCFF_CHAIN_LEN = 65;
  localparam int CCFF_WORD_W    = 8;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer that streams configuration words LSB-first onto the chain head,
// trimming the final word so exactly CHAIN_LEN bits are ever accepted.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter int WORD_W    = CCFF_WORD_W,
  localparam int CW       = $clog2(CHAIN_LEN + 1),
  localparam int RW       = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              shift_en_o,
  output logic              head_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [31:0]       left;
  logic [RW-1:0]     take;
  logic              accept;

  assign left       = 32'(CHAIN_LEN) - 32'(acc_q);
  assign take       = (left >= 32'(WORD_W)) ? RW'(WORD_W) : RW'(left);
  assign shift_en_o = en_i && (rem_q != '0);
  assign head_o     = shift_en_o & word_q[0];
  // Refill while the last buffered bit is leaving so words stream without bubbles.
  assign ready_o    = en_i && (acc_q != CW'(CHAIN_LEN)) && (rem_q <= RW'(1));
  assign accept     = ready_o & valid_i;

  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    acc_d  = acc_q;
    if (clr_i) begin
      word_d = '0;
      rem_d  = '0;
      acc_d  = '0;
    end else if (accept) begin
      word_d = data_i;
      rem_d  = take;
      acc_d  = acc_q + CW'(take);
    end else if (shift_en_o) begin
      word_d = word_q >> 1;
      rem_d  = rem_q - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      rem_q  <= '0;
      acc_q  <= '0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Frame loader for a scan-chain configuration fabric: IDLE/LOAD/DONE control plus
// optional popcount readback check of the previous frame (define CCFF_READBACK_EN).
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN,
  parameter int WORD_W    = CCFF_WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              cfg_done,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  ccff_state_e   state_q;
  logic          busy_q, done_q;
  logic [CW-1:0] bit_cnt_q;
  logic          start_load, last_shift;

  assign start_load = start && !abort && (state_q != LOAD);
  assign last_shift = !abort && (state_q == LOAD) && shift_en &&
                      (bit_cnt_q == CW'(CHAIN_LEN - 1));
  assign busy       = busy_q;
  assign cfg_done   = done_q;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .clk        (prog_clk),
    .rst_n      (prog_reset),
    .clr_i      (abort | start_load),
    .en_i       (state_q == LOAD),
    .data_i     (cfg_data),
    .valid_i    (cfg_valid),
    .ready_o    (cfg_ready),
    .shift_en_o (shift_en),
    .head_o     (ccff_head)
  );

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else if (abort) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q   <= LOAD;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          bit_cnt_q <= '0;
        end
        LOAD: if (shift_en) begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (last_shift) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [CW-1:0] in_cnt_q, out_cnt_q, prev_cnt_q, in_nxt, out_nxt;
  logic          prev_valid_q, err_q;

  assign in_nxt  = in_cnt_q + CW'(ccff_head);
  assign out_nxt = out_cnt_q + CW'(ccff_tail & shift_en);
  assign err     = err_q;

  // The tail replays the previous frame while the new one shifts in, so its
  // popcount must match what was pushed last time.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else if (start_load) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (last_shift) begin
      in_cnt_q     <= in_nxt;
      out_cnt_q    <= out_nxt;
      if (prev_valid_q && (out_nxt != prev_cnt_q)) err_q <= 1'b1;
      prev_cnt_q   <= in_nxt;
      prev_valid_q <= 1'b1;
    end else if (shift_en && !abort) begin
      in_cnt_q  <= in_nxt;
      out_cnt_q <= out_nxt;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: streaming, stall, abort, readback and async reset.
module tb_ccff_loader;

  localparam int LEN = 65;
`ifdef CCFF_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic       prog_clk = 1'b0, prog_reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, ccff_head, ccff_tail, shift_en, cfg_done, busy, err;

  int checks = 0, errors = 0;
  int cyc = 0, shcnt = 0, base = 0, flip_idx = -1;
  logic           sh_n = 1'b0, hd_n = 1'b0;
  logic [LEN-1:0] chain = '0;
  int             sh_cyc [0:2047];
  logic           sh_bit [0:2047];

  ccff_loader #(.CHAIN_LEN(LEN), .WORD_W(8)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .abort      (abort),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .shift_en   (shift_en),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: 65-bit shift register, optional single-bit tail corruption.
  assign ccff_tail = chain[LEN-1] ^ (flip_idx >= 0 && (shcnt - base) == flip_idx);

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (sh_n) begin
      chain <= {chain[LEN-2:0], hd_n};
      shcnt <= shcnt + 1;
    end
  end

  always @(negedge prog_clk) begin
    sh_n <= shift_en;
    hd_n <= ccff_head;
    if (shift_en && shcnt < 2048) begin
      sh_cyc[shcnt] <= cyc;
      sh_bit[shcnt] <= ccff_head;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic feed(input logic [71:0] fr, input int nw, input int stall_after);
    int n;
    for (int i = 0; i < nw; i++) begin
      cfg_data  = fr[i*8 +: 8];
      cfg_valid = 1'b1;
      n = 0;
      while (!cfg_ready && n < 40) begin tick(); n++; end
      chk("ready_wait", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      if (i == stall_after) begin
        n = 0;
        while (!cfg_ready && n < 40) begin tick(); n++; end
        chk("stall_ready", cfg_ready, 1'b1);
        start = 1'b1;
        repeat (5) tick();
        chk("stall_noshift", shift_en, 1'b0);
        start = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [71:0] fr, input int stall_after,
                           input int flip, input logic exp_err);
    int n;
    logic [LEN-1:0] got;
    base = shcnt;
    flip_idx = flip;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_done_clr"}, cfg_done, 1'b0);
    chk({tag, "_err_clr"}, err, 1'b0);
    feed(fr, 9, stall_after);
    chk({tag, "_full_ready"}, cfg_ready, 1'b0);
    n = 0;
    while (!cfg_done && n < 100) begin tick(); n++; end
    chk({tag, "_done"}, cfg_done, 1'b1);
    chk({tag, "_nbits"}, shcnt - base, LEN);
    for (int i = 0; i < LEN; i++) got[i] = sh_bit[base + i];
    chk({tag, "_bits"}, got, fr[LEN-1:0]);
    chk({tag, "_done_lat"}, cyc, sh_cyc[base + LEN - 1] + 1);
    chk({tag, "_span"}, sh_cyc[base + LEN - 1] - sh_cyc[base], (stall_after >= 0) ? 69 : 64);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_shift_off"}, shift_en, 1'b0);
    chk({tag, "_err"}, err, exp_err);
    flip_idx = -1;
  endtask

  initial begin
    logic [71:0] fa, fb, fd, ones, zeros;
    int n;
    fa    = {8'hFE, 8'h96, 8'h7E, 8'h81, 8'hF0, 8'h0F, 8'h5A, 8'hA5, 8'h3C};
    fb    = {8'h01, 8'h18, 8'hE7, 8'h3C, 8'hC3, 8'h88, 8'h44, 8'h22, 8'h11};
    fd    = {8'h01, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    ones  = {72{1'b1}};
    zeros = '0;

    #1 prog_reset = 1'b0;
    #1;
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_shift", shift_en, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b1;
    tick();
    chk("idle_ready", cfg_ready, 1'b0);

    run_frame("stream", fa, -1, -1, 1'b0);
    run_frame("stall", fb, 3, -1, 1'b0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 1'b0);
    chk("abort_start_done", cfg_done, 1'b0);
    chk("abort_start_ready", cfg_ready, 1'b0);

    base = shcnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(zeros, 4, -1);
    n = 0;
    while ((shcnt - base) < 30 && n < 50) begin tick(); n++; end
    chk("abort_pre_shift", shift_en, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", cfg_done, 1'b0);
    chk("abort_shift", shift_en, 1'b0);
    chk("abort_ready", cfg_ready, 1'b0);
    chk("abort_err", err, 1'b0);
    n = shcnt;
    repeat (3) tick();
    chk("abort_stopped", shcnt, n);

    run_frame("reload", fd, -1, -1, RB);
    run_frame("ones", ones, -1, -1, 1'b0);
    run_frame("zeros", zeros, -1, -1, 1'b0);
    run_frame("flip", zeros, -1, 10, RB);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_err_held", err, RB);
    chk("abort_done_clr", cfg_done, 1'b0);

    base = shcnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(zeros, 2, -1);
    @(posedge prog_clk);
    #3;
    chk("mid_busy", busy, 1'b1);
    chk("mid_shift", shift_en, 1'b1);
    prog_reset = 1'b0;
    #1;
    chk("async_ready", cfg_ready, 1'b0);
    chk("async_shift", shift_en, 1'b0);
    chk("async_head", ccff_head, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_done", cfg_done, 1'b0);
    chk("async_err", err, 1'b0);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    tick();

    run_frame("post_reset", zeros, -1, 10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 65: number of configuration bits in the target fle scan chain.
REQ-002 Parameter WORD_W, default 8: configuration word width; legal range 1..32.
REQ-003 prog_clk  in  1: sole clock; all state updates on its rising edge.
REQ-004 prog_reset  in  1: asynchronous, active-low reset.
REQ-005 start  in  1: begin a frame load; sampled only in IDLE or DONE.
REQ-006 abort  in  1: cancel any load in progress.
REQ-007 cfg_data  in  WORD_W: configuration word, LSB shifted first.
REQ-008 cfg_valid  in  1: cfg_data is valid.
REQ-009 cfg_ready  out  1: loader accepts cfg_data this cycle.
REQ-010 ccff_head  out  1: serial bit into the chain.
REQ-011 ccff_tail  in  1: serial bit out of the chain.
REQ-012 shift_en  out  1: chain shifts this cycle.
REQ-013 cfg_done  out  1: full frame loaded.
REQ-014 busy  out  1: high in LOAD.
REQ-015 err  out  1: readback mismatch, sticky until next start.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-017 start=1 in IDLE or DONE SHALL enter LOAD next cycle, clear bit counter, cfg_done and err.
REQ-018 start in LOAD SHALL be ignored.
REQ-019 In LOAD, cfg_ready SHALL be 1 when the word buffer is empty, or when its last remaining bit shifts this cycle (zero-bubble streaming).
REQ-020 A word SHALL be accepted on cfg_valid & cfg_ready; its first bit drives ccff_head on the following cycle.
REQ-021 shift_en SHALL be 1 exactly on cycles where the buffer holds a bit, with ccff_head = that bit; otherwise shift_en=0 and ccff_head=0.
REQ-022 An empty buffer with cfg_valid=0 SHALL stall: shift_en=0, counter held, no timeout.
REQ-023 Total shifted bits SHALL equal exactly CHAIN_LEN; in the final word, bits beyond the remainder CHAIN_LEN mod WORD_W SHALL be discarded.
REQ-024 cfg_ready SHALL be 0 once CHAIN_LEN bits have been accepted into the buffer.
REQ-025 The cycle after the CHAIN_LEN-th shift, the FSM SHALL enter DONE with cfg_done=1, held until start, abort or reset.
REQ-026 abort SHALL override start and take any state to IDLE next cycle, clearing cfg_done, busy, the buffer and the counter; err is held.
REQ-027 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and never wrap.

Reset
REQ-028 prog_reset low SHALL immediately set the state to IDLE, all outputs to 0, and counters, buffer, popcounts and prev_valid to 0.

Configuration
REQ-029 With CCFF_READBACK_EN defined, the loader SHALL popcount the bits shifted in (in_cnt) and the ccff_tail bits sampled on shift_en cycles (out_cnt) during each load.
REQ-030 On entering DONE with prev_valid=1, err SHALL be set if out_cnt differs from the in_cnt saved from the previous completed load.
REQ-031 On entering DONE, in_cnt SHALL then be saved as the previous count and prev_valid set to 1.
REQ-032 An aborted load SHALL neither save in_cnt nor change prev_valid.
REQ-033 Without CCFF_READBACK_EN, err SHALL be tied to 0, ccff_tail SHALL be unused, and no popcount logic SHALL exist.

Structure
REQ-034 A shared package ccff_pkg SHALL hold the state enum typedef (IDLE, LOAD, DONE) and the default CHAIN_LEN/WORD_W constants.
REQ-035 One sub-module, ccff_word_serializer, SHALL implement the word buffer, bit index and ready/shift logic; the FSM and readback logic stay in the top module.

Verification
REQ-036 Stream: CHAIN_LEN=65, WORD_W=8, 9 words fed back-to-back -> 65 consecutive shift_en cycles, cfg_done=1 one cycle after the last shift, and word 8 contributes only its bit0.
REQ-037 Stall: cfg_valid low for 5 cycles after word 3 -> shift_en low for those cycles, no bits lost, and the total is still exactly 65.
REQ-038 Abort: assert abort after 30 shifts -> IDLE next cycle, cfg_done=0; a following full load completes normally.
REQ-039 Readback (macro on): load 0xFF..., then load zeros with ccff_tail modelled as a 65-bit shift register -> err=0; corrupt one tail bit -> err=1.
REQ-040 Reset: drive prog_reset low mid-LOAD, asynchronous to prog_clk -> all outputs 0 immediately, and the first load after release skips the readback compare.
